core_rmw_sequencer: RTL and testbench

//  Sequences the core ALU for 6502 read-modify-write memory ops (ASL/LSR/ROL/ROR/INC/DEC).

---
 rtl/core_rmw_sequencer.sv | 164 ++++++++++++++++
 tb/tb_core_rmw_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_rmw_sequencer.sv
// Read-modify-write sequencer for 6502 memory shift/rotate/inc/dec ops.
// Runs READ -> MODIFY (dummy write) -> WRITE and steers the core ALU for one cycle.
package core_rmw_pkg;
  typedef struct packed {
    logic clear_carry;
    logic set_carry;
    logic rotate_left;
    logic rotate_right;
    logic rhs_pos_one;
    logic rhs_neg_one;
    logic adc_rhs;
    logic result_sign;
    logic result_zero;
  } control_type;
endpackage

module core_rmw_sequencer
  import core_rmw_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter bit DUMMY_WRITE = 1'b1
) (
  input  logic                  I_clock,
  input  logic                  I_reset,
  input  logic                  I_start,
  input  logic [2:0]            I_op,
  input  logic [ADDR_WIDTH-1:0] I_addr,
  input  logic                  I_ready,
  input  logic [7:0]            I_rdata,
  output logic [ADDR_WIDTH-1:0] O_addr,
  output logic                  O_read,
  output logic                  O_write,
  output logic [7:0]            O_wdata,
  output logic                  O_busy,
  output logic                  O_done,
  output control_type           O_alu_control,
  output logic [7:0]            O_alu_lhs,
  output logic [7:0]            O_alu_rhs,
  output logic                  O_alu_mask_p,
  input  logic [7:0]            I_alu_result
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_READ   = 2'd1;
  localparam logic [1:0] S_MODIFY = 2'd2;
  localparam logic [1:0] S_WRITE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            op_q, op_d;
  logic [7:0]            operand_q, operand_d;
  logic [7:0]            result_q, result_d;
  logic [1:0]            out_state;
  logic                  is_nop;

  function automatic control_type op_control(input logic [2:0] op);
    control_type c;
    c = '0;
    case (op)
      3'd0: begin c.clear_carry = 1'b1; c.rotate_left  = 1'b1; c.set_carry = 1'b1; end
      3'd1: begin c.clear_carry = 1'b1; c.rotate_right = 1'b1; c.set_carry = 1'b1; end
      3'd2: begin c.rotate_left  = 1'b1; c.set_carry = 1'b1; end
      3'd3: begin c.rotate_right = 1'b1; c.set_carry = 1'b1; end
      3'd4: begin c.clear_carry = 1'b1; c.rhs_pos_one = 1'b1; c.adc_rhs = 1'b1; end
      3'd5: begin c.clear_carry = 1'b1; c.rhs_neg_one = 1'b1; c.adc_rhs = 1'b1; end
      default: c = '0;
    endcase
    if (op < 3'd6) begin
      c.result_sign = 1'b1;
      c.result_zero = 1'b1;
    end
    return c;
  endfunction

  assign is_nop = op_q[2] & op_q[1];

  // Reset forces the output decode to IDLE in the same cycle, so an abort
  // suppresses any pending bus write and the flag update immediately.
  assign out_state = I_reset ? S_IDLE : state_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    op_d      = op_q;
    operand_d = operand_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (I_start) begin
          addr_d  = I_addr;
          op_d    = I_op;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (I_ready) begin
          operand_d = I_rdata;
          state_d   = S_MODIFY;
        end
      end
      S_MODIFY: begin
        result_d = is_nop ? operand_q : I_alu_result;
        state_d  = S_WRITE;
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge I_clock) begin
    addr_q    <= addr_d;
    op_q      <= op_d;
    operand_q <= operand_d;
    result_q  <= result_d;
  end

  always_comb begin
    O_addr        = '0;
    O_read        = 1'b0;
    O_write       = 1'b0;
    O_wdata       = '0;
    O_busy        = 1'b0;
    O_done        = 1'b0;
    O_alu_control = '0;
    O_alu_lhs     = '0;
    O_alu_mask_p  = 1'b0;
    case (out_state)
      S_READ: begin
        O_addr = addr_q;
        O_read = 1'b1;
        O_busy = 1'b1;
      end
      S_MODIFY: begin
        O_addr        = addr_q;
        O_write       = DUMMY_WRITE;
        O_read        = ~DUMMY_WRITE;
        O_wdata       = operand_q;
        O_busy        = 1'b1;
        O_alu_control = op_control(op_q);
        O_alu_lhs     = operand_q;
        O_alu_mask_p  = ~is_nop;
      end
      S_WRITE: begin
        O_addr  = addr_q;
        O_write = 1'b1;
        O_wdata = result_q;
        O_busy  = 1'b1;
        O_done  = 1'b1;
      end
      default: O_busy = 1'b0;
    endcase
  end

  assign O_alu_rhs = 8'h00;

endmodule

// File: tb/tb_core_rmw_sequencer.sv
// Bench for core_rmw_sequencer: behavioural ALU + P-flag model, vector table,
// write scoreboard, plus reset-abort and no-dummy-write sequences.
module tb_core_rmw_sequencer;
  import core_rmw_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, ready;
  logic [2:0]  op;
  logic [15:0] addr;
  logic [7:0]  rdata;
  logic [15:0] o_addr;
  logic        o_read, o_write, o_busy, o_done, o_mask;
  logic [7:0]  o_wdata, o_lhs, o_rhs, alu_res;
  control_type o_ctl;
  logic [8:0]  alu_out;

  logic        start2, ready2;
  logic [2:0]  op2;
  logic [15:0] addr2;
  logic [7:0]  rdata2;
  logic [15:0] o2_addr;
  logic        o2_read, o2_write, o2_busy, o2_done, o2_mask;
  logic [7:0]  o2_wdata, o2_lhs, o2_rhs, alu2_res;
  control_type o2_ctl;
  logic [8:0]  alu2_out;

  logic        p_c, p_n, p_z;
  logic        p_load;
  logic [2:0]  p_load_v;

  int n_cmp = 0;
  int n_bad = 0;
  logic [23:0] exp_q[$];

  core_rmw_sequencer #(.ADDR_WIDTH(16), .DUMMY_WRITE(1'b1)) dut (
    .I_clock(clk), .I_reset(rst), .I_start(start), .I_op(op), .I_addr(addr),
    .I_ready(ready), .I_rdata(rdata), .O_addr(o_addr), .O_read(o_read),
    .O_write(o_write), .O_wdata(o_wdata), .O_busy(o_busy), .O_done(o_done),
    .O_alu_control(o_ctl), .O_alu_lhs(o_lhs), .O_alu_rhs(o_rhs),
    .O_alu_mask_p(o_mask), .I_alu_result(alu_res)
  );

  core_rmw_sequencer #(.ADDR_WIDTH(16), .DUMMY_WRITE(1'b0)) dut_nd (
    .I_clock(clk), .I_reset(rst), .I_start(start2), .I_op(op2), .I_addr(addr2),
    .I_ready(ready2), .I_rdata(rdata2), .O_addr(o2_addr), .O_read(o2_read),
    .O_write(o2_write), .O_wdata(o2_wdata), .O_busy(o2_busy), .O_done(o2_done),
    .O_alu_control(o2_ctl), .O_alu_lhs(o2_lhs), .O_alu_rhs(o2_rhs),
    .O_alu_mask_p(o2_mask), .I_alu_result(alu2_res)
  );

  // Behavioural 6502 ALU subset: returns {carry_out, result}.
  function automatic logic [8:0] alu_fn(input control_type c, input logic [7:0] lhs,
                                        input logic [7:0] rhs, input logic cin_p);
    logic       cin;
    logic [7:0] k;
    logic [8:0] s;
    cin = c.clear_carry ? 1'b0 : cin_p;
    s   = {cin_p, lhs};
    if (c.rotate_left) begin
      s = {lhs[7], lhs[6:0], cin};
    end else if (c.rotate_right) begin
      s = {lhs[0], cin, lhs[7:1]};
    end else if (c.adc_rhs) begin
      k = c.rhs_pos_one ? 8'h01 : (c.rhs_neg_one ? 8'hFF : rhs);
      s = {1'b0, lhs} + {1'b0, k} + {8'h00, cin};
    end
    return s;
  endfunction

  assign alu_out  = alu_fn(o_ctl, o_lhs, o_rhs, p_c);
  assign alu_res  = alu_out[7:0];
  assign alu2_out = alu_fn(o2_ctl, o2_lhs, o2_rhs, 1'b0);
  assign alu2_res = alu2_out[7:0];

  always @(posedge clk) begin
    if (p_load) begin
      {p_c, p_n, p_z} <= p_load_v;
    end else if (o_mask) begin
      if (o_ctl.set_carry)   p_c <= alu_out[8];
      if (o_ctl.result_sign) p_n <= alu_out[7];
      if (o_ctl.result_zero) p_z <= (alu_out[7:0] == 8'h00);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every bus write of the main instance must match the next expectation.
  always @(negedge clk) begin
    if (o_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected write: addr %0h data %0h, none expected", o_addr, o_wdata);
      end else begin
        chk("bus write {addr,data}", {8'h00, o_addr, o_wdata}, {8'h00, exp_q.pop_front()});
      end
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [7:0]  rdata;
    int          stall;
    bit          poke;
    logic [2:0]  p_in;
    control_type ctl;
    bit          mask;
    logic [7:0]  res;
    logic [2:0]  p_exp;
    string       name;
  } vec_t;

  vec_t vecs[9];

  // Entered at a falling edge with the DUT idle; returns at a falling edge, idle again.
  task automatic run(input vec_t v);
    int mcnt;
    bit done_seen;
    chk({v.name, " idle before start"}, 32'(o_busy), 32'd0);
    p_load   = 1'b1;
    p_load_v = v.p_in;
    start    = 1'b1;
    op       = v.op;
    addr     = v.addr;
    rdata    = v.rdata;
    ready    = 1'b1;
    exp_q.push_back({v.addr, v.rdata});
    exp_q.push_back({v.addr, v.res});
    mcnt = 0;
    done_seen = 1'b0;
    for (int k = 1; k <= 20 && !done_seen; k++) begin
      @(negedge clk);
      p_load = 1'b0;
      start  = v.poke;
      ready  = (k > v.stall);
      chk({v.name, " busy"}, 32'(o_busy), 32'd1);
      if (o_read) chk({v.name, " read addr"}, 32'(o_addr), 32'(v.addr));
      if (o_write && !o_done) begin
        chk({v.name, " ctl"}, 32'(o_ctl), 32'(v.ctl));
        chk({v.name, " mask_p"}, 32'(o_mask), 32'(v.mask));
        chk({v.name, " lhs"}, 32'(o_lhs), 32'(v.rdata));
        chk({v.name, " rhs"}, 32'(o_rhs), 32'd0);
      end else begin
        chk({v.name, " ctl idle"}, 32'(o_ctl), 32'd0);
      end
      if (o_mask) mcnt++;
      if (o_done) begin
        chk({v.name, " latency"}, 32'(k), 32'(3 + v.stall));
        done_seen = 1'b1;
      end
    end
    if (!done_seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: done not seen within 20 cycles", v.name);
    end
    start = 1'b0;
    @(negedge clk);
    chk({v.name, " busy after"}, 32'(o_busy), 32'd0);
    chk({v.name, " done after"}, 32'(o_done), 32'd0);
    chk({v.name, " mask count"}, 32'(mcnt), 32'(v.mask));
    chk({v.name, " P {C,N,Z}"}, 32'({p_c, p_n, p_z}), 32'(v.p_exp));
    chk({v.name, " writes left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    control_type c_asl, c_lsr, c_rol, c_ror, c_inc, c_dec, c_nop;
    c_asl = '{clear_carry: 1'b1, rotate_left: 1'b1, set_carry: 1'b1,
              result_sign: 1'b1, result_zero: 1'b1, default: 1'b0};
    c_lsr = '{clear_carry: 1'b1, rotate_right: 1'b1, set_carry: 1'b1,
              result_sign: 1'b1, result_zero: 1'b1, default: 1'b0};
    c_rol = '{rotate_left: 1'b1, set_carry: 1'b1,
              result_sign: 1'b1, result_zero: 1'b1, default: 1'b0};
    c_ror = '{rotate_right: 1'b1, set_carry: 1'b1,
              result_sign: 1'b1, result_zero: 1'b1, default: 1'b0};
    c_inc = '{clear_carry: 1'b1, rhs_pos_one: 1'b1, adc_rhs: 1'b1,
              result_sign: 1'b1, result_zero: 1'b1, default: 1'b0};
    c_dec = '{clear_carry: 1'b1, rhs_neg_one: 1'b1, adc_rhs: 1'b1,
              result_sign: 1'b1, result_zero: 1'b1, default: 1'b0};
    c_nop = '0;
    //               op    addr      rdata  stl poke p_in(CNZ) ctl   mask res    p_exp
    vecs[0] = '{3'd0, 16'h0200, 8'h81, 0, 1'b0, 3'b011, c_asl, 1'b1, 8'h02, 3'b100, "ASL"};
    vecs[1] = '{3'd5, 16'h00FF, 8'h00, 0, 1'b0, 3'b101, c_dec, 1'b1, 8'hFF, 3'b110, "DEC"};
    vecs[2] = '{3'd3, 16'h0040, 8'h01, 2, 1'b0, 3'b101, c_ror, 1'b1, 8'h80, 3'b110, "ROR"};
    vecs[3] = '{3'd1, 16'h1234, 8'h01, 1, 1'b0, 3'b010, c_lsr, 1'b1, 8'h00, 3'b101, "LSR"};
    vecs[4] = '{3'd2, 16'hFFFF, 8'h80, 0, 1'b0, 3'b111, c_rol, 1'b1, 8'h01, 3'b100, "ROL"};
    vecs[5] = '{3'd4, 16'h0010, 8'h7F, 0, 1'b0, 3'b001, c_inc, 1'b1, 8'h80, 3'b010, "INC"};
    vecs[6] = '{3'd4, 16'h0011, 8'h00, 0, 1'b0, 3'b111, c_inc, 1'b1, 8'h01, 3'b100, "INC_C1"};
    vecs[7] = '{3'd6, 16'h0123, 8'h5A, 1, 1'b1, 3'b101, c_nop, 1'b0, 8'h5A, 3'b101, "NOP6"};
    vecs[8] = '{3'd7, 16'h4567, 8'hA5, 0, 1'b1, 3'b010, c_nop, 1'b0, 8'hA5, 3'b010, "NOP7"};

    rst = 1'b1; start = 1'b1; ready = 1'b1; op = 3'd0; addr = 16'hBEEF; rdata = 8'h00;
    p_load = 1'b0; p_load_v = 3'b000;
    start2 = 1'b0; ready2 = 1'b1; op2 = 3'd0; addr2 = 16'h0000; rdata2 = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset read/write/done/mask", 32'({o_read, o_write, o_done, o_mask}), 32'd0);
    chk("reset addr", 32'(o_addr), 32'd0);
    chk("reset wdata/lhs", 32'({o_wdata, o_lhs}), 32'd0);
    chk("reset ctl", 32'(o_ctl), 32'd0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset busy", 32'(o_busy), 32'd0);

    for (int i = 0; i < 9; i++) run(vecs[i]);

    // Reset during MODIFY: dummy write happens, the final write and flag update must not.
    p_load = 1'b1; p_load_v = 3'b101;
    start = 1'b1; op = 3'd0; addr = 16'h0300; rdata = 8'h40; ready = 1'b1;
    exp_q.push_back({16'h0300, 8'h40});
    @(negedge clk);
    p_load = 1'b0; start = 1'b0;
    chk("abort in READ", 32'(o_read), 32'd1);
    @(negedge clk);
    chk("abort in MODIFY mask", 32'(o_mask), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort write gated", 32'(o_write), 32'd0);
    chk("abort mask gated", 32'(o_mask), 32'd0);
    chk("abort busy gated", 32'(o_busy), 32'd0);
    chk("abort ctl gated", 32'(o_ctl), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort idle busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    chk("abort idle write", 32'(o_write), 32'd0);
    chk("abort P unchanged", 32'({p_c, p_n, p_z}), 32'b101);
    chk("abort writes left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // DUMMY_WRITE=0 instance: MODIFY is a read cycle, INC 0xFF wraps to 0x00.
    start2 = 1'b1; op2 = 3'd4; addr2 = 16'h0777; rdata2 = 8'hFF;
    @(negedge clk);
    start2 = 1'b0;
    chk("ND read", 32'({o2_read, o2_write}), 32'b10);
    @(negedge clk);
    chk("ND modify read/write", 32'({o2_read, o2_write}), 32'b10);
    chk("ND modify ctl", 32'(o2_ctl), 32'(c_inc));
    chk("ND modify mask", 32'(o2_mask), 32'd1);
    chk("ND modify Z", 32'(o2_ctl.result_zero && (alu2_res == 8'h00)), 32'd1);
    @(negedge clk);
    chk("ND write strobe/done", 32'({o2_write, o2_done}), 32'b11);
    chk("ND write data", 32'({o2_addr, o2_wdata}), 32'h077700);
    @(negedge clk);
    chk("ND idle", 32'(o2_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
